// File: rtl/fb_pkg.sv
// Shared constants and types for the framebuffer write scheduler.
package fb_pkg;

    localparam int FB_ADDR_WIDTH = 13;
    localparam int FB_DATA_WIDTH = 8;
    localparam int FB_NUM_WORDS  = 6144;   // 128 x 48 pixels per page

    // Scheduler states: RUN serves writers, SWAP_WAIT holds them off until
    // the scanner reaches a frame boundary.
    typedef enum logic {
        ST_RUN       = 1'b0,
        ST_SWAP_WAIT = 1'b1
    } fb_state_t;

    // Requester indices, also used as the encoding of the arbiter's memory.
    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/fb_write_sched_if.sv
// Writer-side handshakes and the RAM write port of the framebuffer scheduler.
interface fb_write_sched_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 8
);
    logic                  a_valid;
    logic                  a_ready;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_data;

    logic                  b_valid;
    logic                  b_ready;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_data;

    logic                  wr_enable;
    logic [ADDR_WIDTH:0]   wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    // The scheduler: consumes writer requests, drives the RAM port.
    modport slave (
        input  a_valid, a_addr, a_data,
        output a_ready,
        input  b_valid, b_addr, b_data,
        output b_ready,
        output wr_enable, wr_addr, wr_data
    );

    // The environment: writers plus the RAM.
    modport master (
        output a_valid, a_addr, a_data,
        input  a_ready,
        output b_valid, b_addr, b_data,
        input  b_ready,
        input  wr_enable, wr_addr, wr_data
    );
endinterface

// File: rtl/fb_write_sched_rr_arb2.sv
// Two-input round-robin arbiter. On a tie the requester that did not win
// the last accepted transfer is granted; the memory resets to B so A wins
// the first tie after reset.
module rr_arb2
    import fb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic valid_a,
    input  logic valid_b,
    input  logic accept,     // the current grant was taken this cycle
    output logic grant_a,
    output logic grant_b
);

    logic last_grant;

    // Grant selection: single requester wins outright, ties alternate.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (valid_a && valid_b) begin
            if (last_grant == REQ_A) grant_b = 1'b1;
            else                     grant_a = 1'b1;
        end else begin
            grant_a = valid_a;
            grant_b = valid_b;
        end
    end

    // Remember who was served last, only when a transfer actually happens.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset)       last_grant <= REQ_B;
        else if (accept) last_grant <= grant_b ? REQ_B : REQ_A;
    end

endmodule

// File: rtl/fb_write_sched.sv
// Framebuffer write scheduler: arbitrates two pixel writers onto the single
// RAM write port, always into the back page, and flips pages only at a
// scanner frame boundary so the panel never shows a torn frame.
module fb_write_sched
    import fb_pkg::*;
#(
    parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
    parameter int DATA_WIDTH = FB_DATA_WIDTH,
    parameter int NUM_WORDS  = FB_NUM_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    fb_write_sched_if.slave   bus,
    input  logic              swap_req,
    input  logic              frame_start,
    output logic              rd_page,
    output logic              swap_done,
    output logic [7:0]        drop_count
);

    localparam logic [ADDR_WIDTH-1:0] LAST_VALID = ADDR_WIDTH'(NUM_WORDS - 1);

    fb_state_t             state_q, state_d;
    logic                  flip;
    logic                  run_en;
    logic                  grant_a, grant_b;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  in_range;

    logic                  wr_enable_q;
    logic [ADDR_WIDTH:0]   wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;

    // Writers are served only in RUN and never while reset is held, so the
    // readies drop immediately when reset rises.
    assign run_en = (state_q == ST_RUN) && !reset;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .valid_a (bus.a_valid),
        .valid_b (bus.b_valid),
        .accept  (accept),
        .grant_a (grant_a),
        .grant_b (grant_b)
    );

    assign bus.a_ready = grant_a && run_en;
    assign bus.b_ready = grant_b && run_en;
    assign accept      = run_en && (bus.a_valid || bus.b_valid);

    // Mux the winning request; out-of-range writes are still accepted so a
    // bad writer cannot stall the port, but they never reach the RAM.
    always_comb begin
        sel_addr = bus.b_addr;
        sel_data = bus.b_data;
        if (grant_a) begin
            sel_addr = bus.a_addr;
            sel_data = bus.a_data;
        end
        in_range = (sel_addr <= LAST_VALID);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    // FSM next state: a flip request parks writers until the next frame
    // boundary; a frame_start in the request cycle is seen while still in
    // RUN and therefore cannot satisfy it.
    always_comb begin
        state_d = state_q;
        flip    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (swap_req) state_d = ST_SWAP_WAIT;
            end
            ST_SWAP_WAIT: begin
                if (frame_start) begin
                    state_d = ST_RUN;
                    flip    = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Page select and flip acknowledge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_page   <= 1'b0;
            swap_done <= 1'b0;
        end else begin
            rd_page   <= rd_page ^ flip;
            swap_done <= flip;
        end
    end

    // One-cycle write pipeline; the back page is captured at acceptance so
    // a write accepted alongside a flip still lands in the old back page.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_enable_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            wr_enable_q <= accept && in_range;
            if (accept) begin
                wr_addr_q <= {~rd_page, sel_addr};
                wr_data_q <= sel_data;
            end
        end
    end

    // Saturating count of accepted writes that were discarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            drop_count <= '0;
        else if (accept && !in_range && drop_count != 8'hFF)
            drop_count <= drop_count + 8'd1;
    end

    assign bus.wr_enable = wr_enable_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;

endmodule

// File: tb/tb_fb_write_sched.sv
// Directed bench for fb_write_sched with a write scoreboard and monitor.
module tb_fb_write_sched;

    logic       clk;
    logic       reset;
    logic       swap_req;
    logic       frame_start;
    logic       rd_page;
    logic       swap_done;
    logic [7:0] drop_count;

    fb_write_sched_if #(.ADDR_WIDTH(13), .DATA_WIDTH(8)) bus ();

    fb_write_sched #(.ADDR_WIDTH(13), .DATA_WIDTH(8), .NUM_WORDS(6144)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .swap_req    (swap_req),
        .frame_start (frame_start),
        .rd_page     (rd_page),
        .swap_done   (swap_done),
        .drop_count  (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_swap_done = 0;
    logic [21:0] sb[$];          // {wr_addr[13:0], wr_data[7:0]}
    logic        exp_rd_page = 1'b0;
    logic [7:0]  exp_drop = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of what an accepted write must produce.
    task automatic accept_model(input logic [12:0] addr, input logic [7:0] data);
        if (addr < 13'd6144) sb.push_back({~exp_rd_page, addr, data});
        else if (exp_drop != 8'hFF) exp_drop = exp_drop + 8'd1;
    endtask

    // One cycle: drive at posedge+1, check readies at negedge, record model.
    task automatic issue(input string tag,
                         input logic av, input logic [12:0] aa, input logic [7:0] ad,
                         input logic bv, input logic [12:0] ba, input logic [7:0] bd,
                         input logic era, input logic erb);
        bus.a_valid = av; bus.a_addr = aa; bus.a_data = ad;
        bus.b_valid = bv; bus.b_addr = ba; bus.b_data = bd;
        @(negedge clk);
        check({tag, "_a_ready"}, 32'(bus.a_ready), 32'(era));
        check({tag, "_b_ready"}, 32'(bus.b_ready), 32'(erb));
        if (era) accept_model(aa, ad);
        if (erb) accept_model(ba, bd);
        @(posedge clk); #1;
    endtask

    // Monitor: every RAM write must match the oldest expected one.
    always @(negedge clk) begin
        if (swap_done) n_swap_done++;
        if (bus.wr_enable) begin
            if (sb.size() == 0) begin
                check("unexpected_write", 32'(bus.wr_addr), 32'h0);
                check("unexpected_write_en", 32'(bus.wr_enable), 32'h0);
            end else begin
                logic [21:0] e;
                e = sb.pop_front();
                check("wr_addr", 32'(bus.wr_addr), 32'(e[21:8]));
                check("wr_data", 32'(bus.wr_data), 32'(e[7:0]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; swap_req = 1'b0; frame_start = 1'b0;
        bus.a_valid = 1'b1; bus.a_addr = 13'h010; bus.a_data = 8'h5A;
        bus.b_valid = 1'b1; bus.b_addr = 13'h020; bus.b_data = 8'h33;

        // Reset state, with requests pending.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_a_ready", 32'(bus.a_ready), 0);
        check("rst_b_ready", 32'(bus.b_ready), 0);
        check("rst_wr_enable", 32'(bus.wr_enable), 0);
        check("rst_wr_addr", 32'(bus.wr_addr), 0);
        check("rst_wr_data", 32'(bus.wr_data), 0);
        check("rst_rd_page", 32'(rd_page), 0);
        check("rst_swap_done", 32'(swap_done), 0);
        check("rst_drop", 32'(drop_count), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // First write: A only, lands in back page 1 one cycle later.
        issue("t1", 1, 13'h010, 8'h5A, 0, 13'h0, 8'h0, 1, 0);
        check("t1_wr_enable", 32'(bus.wr_enable), 1);
        check("t1_wr_addr", 32'(bus.wr_addr), 32'h2010);
        issue("t1_idle", 0, 13'h0, 8'h0, 0, 13'h0, 8'h0, 0, 0);

        // B alone, then ties alternate A,B,A,B.
        issue("t2_b", 0, 13'h0, 8'h0, 1, 13'h020, 8'h33, 0, 1);
        issue("t2_c1", 1, 13'h100, 8'h11, 1, 13'h200, 8'h21, 1, 0);
        issue("t2_c2", 1, 13'h101, 8'h12, 1, 13'h200, 8'h21, 0, 1);
        issue("t2_c3", 1, 13'h101, 8'h12, 1, 13'h201, 8'h22, 1, 0);
        issue("t2_c4", 1, 13'h102, 8'h13, 1, 13'h201, 8'h22, 0, 1);
        issue("t2_idle", 0, 13'h0, 8'h0, 0, 13'h0, 8'h0, 0, 0);

        // Last valid word, then first invalid one.
        issue("t3_last", 1, 13'd6143, 8'hC3, 0, 13'h0, 8'h0, 1, 0);
        issue("t3_oor", 0, 13'h0, 8'h0, 1, 13'd6144, 8'hEE, 0, 1);
        check("t3_oor_wr_enable", 32'(bus.wr_enable), 0);
        check("t3_drop1", 32'(drop_count), 32'(exp_drop));
        for (int i = 0; i < 299; i++)
            issue("t3_sat", 0, 13'h0, 8'h0, 1, 13'(6144 + (i % 2048)), 8'(i), 0, 1);
        issue("t3_idle", 0, 13'h0, 8'h0, 0, 13'h0, 8'h0, 0, 0);
        check("t3_drop255", 32'(drop_count), 32'd255);

        // Flip request with frame_start in the same cycle; the write accepted
        // alongside it still targets page 1.
        swap_req = 1'b1; frame_start = 1'b1;
        issue("t4_req", 1, 13'h030, 8'h77, 0, 13'h0, 8'h0, 1, 0);
        swap_req = 1'b0; frame_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue("t4_hold", 1, 13'h031, 8'h78, 0, 13'h0, 8'h0, 0, 0);
            check("t4_hold_rd_page", 32'(rd_page), 0);
        end
        frame_start = 1'b1;
        issue("t4_fs", 1, 13'h031, 8'h78, 0, 13'h0, 8'h0, 0, 0);
        frame_start = 1'b0;
        exp_rd_page = 1'b1;
        check("t4_rd_page", 32'(rd_page), 32'(exp_rd_page));
        check("t4_swap_done", 32'(swap_done), 1);
        issue("t4_resume", 1, 13'h031, 8'h78, 0, 13'h0, 8'h0, 1, 0);
        check("t4_swap_done_once", 32'(swap_done), 0);
        check("t4_wr_addr_msb", 32'(bus.wr_addr[13]), 0);
        issue("t4_idle", 0, 13'h0, 8'h0, 0, 13'h0, 8'h0, 0, 0);

        // Repeated request while waiting must not double flip.
        swap_req = 1'b1;
        issue("t5_req1", 0, 13'h0, 8'h0, 0, 13'h0, 8'h0, 0, 0);
        issue("t5_req2", 0, 13'h0, 8'h0, 0, 13'h0, 8'h0, 0, 0);
        swap_req = 1'b0;
        issue("t5_wait", 0, 13'h0, 8'h0, 0, 13'h0, 8'h0, 0, 0);
        frame_start = 1'b1;
        issue("t5_fs", 0, 13'h0, 8'h0, 0, 13'h0, 8'h0, 0, 0);
        frame_start = 1'b0;
        exp_rd_page = 1'b0;
        check("t5_rd_page", 32'(rd_page), 32'(exp_rd_page));
        check("t5_swap_done", 32'(swap_done), 1);
        frame_start = 1'b1;
        issue("t5_fs_run", 0, 13'h0, 8'h0, 0, 13'h0, 8'h0, 0, 0);
        frame_start = 1'b0;
        check("t5_rd_page_run", 32'(rd_page), 32'(exp_rd_page));
        check("t5_swap_done_run", 32'(swap_done), 0);

        // Flip to page 1, then enter SWAP_WAIT with a write in flight and
        // reset mid-wait: everything clears at once and the flip is lost.
        swap_req = 1'b1;
        issue("t6_req0", 0, 13'h0, 8'h0, 0, 13'h0, 8'h0, 0, 0);
        swap_req = 1'b0; frame_start = 1'b1;
        issue("t6_fs0", 0, 13'h0, 8'h0, 0, 13'h0, 8'h0, 0, 0);
        frame_start = 1'b0;
        exp_rd_page = 1'b1;
        check("t6_rd_page_pre", 32'(rd_page), 32'(exp_rd_page));
        swap_req = 1'b1;
        issue("t6_req", 1, 13'h040, 8'h99, 0, 13'h0, 8'h0, 1, 0);
        swap_req = 1'b0;
        check("t6_inflight", 32'(bus.wr_enable), 1);
        reset = 1'b1;
        sb.delete();
        exp_rd_page = 1'b0;
        exp_drop = 8'd0;
        #1;
        check("t6_async_wr_enable", 32'(bus.wr_enable), 0);
        check("t6_async_wr_addr", 32'(bus.wr_addr), 0);
        check("t6_async_wr_data", 32'(bus.wr_data), 0);
        check("t6_async_rd_page", 32'(rd_page), 0);
        check("t6_async_a_ready", 32'(bus.a_ready), 0);
        check("t6_async_drop", 32'(drop_count), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        frame_start = 1'b1;
        issue("t6_fs_after", 0, 13'h0, 8'h0, 0, 13'h0, 8'h0, 0, 0);
        frame_start = 1'b0;
        check("t6_no_flip", 32'(rd_page), 0);
        check("t6_no_swap_done", 32'(swap_done), 0);
        issue("t6_write", 1, 13'h050, 8'h42, 0, 13'h0, 8'h0, 1, 0);
        check("t6_wr_addr", 32'(bus.wr_addr), 32'h2050);
        issue("t6_idle", 0, 13'h0, 8'h0, 0, 13'h0, 8'h0, 0, 0);
        issue("t6_idle2", 0, 13'h0, 8'h0, 0, 13'h0, 8'h0, 0, 0);

        check("sb_drained", 32'(sb.size()), 0);
        check("swap_done_pulses", 32'(n_swap_done), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
